fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of async_fifo among NUM_REQ requesters in the write-clock domain. It grants one requester at a time for a packet burst, gates every accepted beat on the FIFO full flag, and drives write_en/wdata. It caps each burst at MAX_BURST beats so that no requester can starve the others.

---
 rtl/fifo_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port among NUM_REQ requesters.
// Grants one requester per packet burst, stalls on full, caps bursts at MAX_BURST beats.
module fifo_write_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = 9,
    parameter  int MAX_BURST = 8,
    localparam int OWN_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic [OWN_W-1:0]          owner,
    output logic                      busy,
    output logic                      trunc,
    input  logic                      full,
    output logic                      write_en,
    output logic [DATA_W-1:0]         wdata
);

    typedef enum logic [0:0] {S_IDLE, S_BURST} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [OWN_W-1:0]     r_owner;
    logic [OWN_W-1:0]     r_rr_ptr;
    logic                 r_busy;
    logic                 r_trunc;
    logic [CNT_W-1:0]     r_beat_cnt;

    logic                 w_any_req;
    logic                 w_found;
    logic [OWN_W-1:0]     w_sel;
    logic [NUM_REQ-1:0]   w_sel_oh;
    int unsigned          w_idx;
    logic                 w_own_req;
    logic                 w_own_last;
    logic                 w_own_ack;
    logic                 w_at_cap;
    logic                 w_rel_last;
    logic                 w_rel_cap;
    logic                 w_rel_abandon;
    logic                 w_release;
    logic [OWN_W-1:0]     w_rr_nxt;

    assign w_any_req = |req;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_idx    = 0;
        for (int unsigned k = 0; k < int'(NUM_REQ); k++) begin
            w_idx = (int'(r_rr_ptr) + k) % int'(NUM_REQ);
            if (!w_found && req[OWN_W'(w_idx)]) begin
                w_found = 1'b1;
                w_sel   = OWN_W'(w_idx);
            end
        end
        w_sel_oh        = '0;
        w_sel_oh[w_sel] = 1'b1;
    end

    assign w_own_req     = req[r_owner];
    assign w_own_last    = req_last[r_owner];
    assign w_own_ack     = |ack;
    assign w_at_cap      = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    assign w_rel_last    = w_own_ack & w_own_last;
    // A last beat landing on the cap is a normal end of packet, not a truncation.
    assign w_rel_cap     = w_own_ack & w_at_cap & ~w_own_last;
    assign w_rel_abandon = ~w_own_req;
    assign w_release     = w_rel_last | w_rel_cap | w_rel_abandon;
    assign w_rr_nxt      = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + OWN_W'(1);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_BURST;
            S_BURST: if (w_release) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack      = r_grant & req & {NUM_REQ{~full}};
        write_en = |ack;
        wdata    = write_en ? req_data[r_owner*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_grant    <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= w_sel_oh;
                        r_owner    <= w_sel;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (w_release) begin
                        r_grant  <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_rr_nxt;
                        r_trunc  <= w_rel_cap;
                    end else if (w_own_ack) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign trunc = r_trunc;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a per-cycle vector table plus
// requester-driven sequences for stall, burst cap and mid-burst reset.
module tb_fifo_write_arbiter;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req;
    logic [35:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic        trunc;
    logic        full;
    logic        write_en;
    logic [8:0]  wdata;

    int checks = 0;
    int errors = 0;
    int exp_wc[16];

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (9),
        .MAX_BURST(8)
    ) dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .req     (req),
        .req_data(req_data),
        .req_last(req_last),
        .ack     (ack),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .trunc   (trunc),
        .full    (full),
        .write_en(write_en),
        .wdata   (wdata)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  rq;
        logic [3:0]  lst;
        logic        fl;
        logic [35:0] d;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic [3:0]  e_ack;
        logic        e_we;
        logic [8:0]  e_wdata;
        logic        e_trunc;
    } vec_t;

    vec_t tv[40];
    int   ntv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] pk(input logic [8:0] a0, input logic [8:0] a1,
                                       input logic [8:0] a2, input logic [8:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] lst,
                       input logic fl, input logic [35:0] d, input logic [3:0] eg,
                       input logic eb, input logic [3:0] ea, input logic ew,
                       input logic [8:0] ed, input logic et);
        tv[ntv].rst_n   = rst;
        tv[ntv].rq      = rq;
        tv[ntv].lst     = lst;
        tv[ntv].fl      = fl;
        tv[ntv].d       = d;
        tv[ntv].e_grant = eg;
        tv[ntv].e_busy  = eb;
        tv[ntv].e_ack   = ea;
        tv[ntv].e_we    = ew;
        tv[ntv].e_wdata = ed;
        tv[ntv].e_trunc = et;
        ntv++;
    endtask

    task automatic drive(input logic rst, input logic [3:0] rq, input logic [3:0] lst,
                         input logic fl, input logic [35:0] d);
        @(negedge wclk);
        wrst_n   = rst;
        req      = rq;
        req_last = lst;
        full     = fl;
        req_data = d;
        #1;
    endtask

    // Requester r offers n words base, base+1, ...; full is raised for stall_len
    // cycles while word index stall_at is pending.
    task automatic run_stream(input int r, input int n, input logic [8:0] base,
                              input int stall_at, input int stall_len, input int ncyc,
                              input int exp_trunc, input string tag);
        int         wi = 0;
        int         sc = 0;
        int         nw = 0;
        int         nt = 0;
        int         tc = -1;
        int         wc[32];
        logic [8:0] wv[32];
        logic [8:0] ev;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge wclk);
            req      = '0;
            req_last = '0;
            req_data = '0;
            if (wi < n) begin
                req[r]             = 1'b1;
                req_data[r*9 +: 9] = base + 9'(wi);
                req_last[r]        = (wi == n - 1);
            end
            full = (wi == stall_at) && (sc < stall_len);
            #1;
            chk($sformatf("%s_inv_c%0d", tag, c),
                {29'd0, write_en & full, write_en & ~busy, $onehot0(grant)}, 32'd1);
            if (full) begin
                sc++;
                chk($sformatf("%s_stall_grant_c%0d", tag, c), {28'd0, grant}, 32'(4'b0001 << r));
                chk($sformatf("%s_stall_we_c%0d", tag, c), {31'd0, write_en}, 32'd0);
            end
            if (write_en && nw < 32) begin
                wc[nw] = c;
                wv[nw] = wdata;
                nw++;
            end
            if (trunc) begin
                nt++;
                tc = c;
            end
            if (ack[r]) wi++;
        end
        req      = '0;
        req_last = '0;
        full     = 1'b0;
        chk($sformatf("%s_nwrites", tag), nw, n);
        for (int i = 0; i < nw && i < n; i++) begin
            ev = base + 9'(i);
            chk($sformatf("%s_data%0d", tag, i), {23'd0, wv[i]}, {23'd0, ev});
            chk($sformatf("%s_cycle%0d", tag, i), wc[i], exp_wc[i]);
        end
        chk($sformatf("%s_ntrunc", tag), nt, (exp_trunc >= 0) ? 1 : 0);
        if (exp_trunc >= 0) chk($sformatf("%s_trunc_cycle", tag), tc, exp_trunc);
    endtask

    initial begin
        logic [35:0] rr;
        int          eo;
        wrst_n   = 1'b0;
        req      = 4'b1111;
        req_last = '0;
        full     = 1'b0;
        req_data = '0;
        rr       = pk(9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3);

        // reset held with all requests pending, then first grant to 0
        add(0, 4'b1111, 4'b0000, 0, '0, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(0, 4'b1111, 4'b0000, 0, '0, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(0, 4'b1111, 4'b0000, 0, '0, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b1111, 4'b1111, 0, '0, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b0001, 4'b0001, 0, pk(9'h0AA, 0, 0, 0), 4'b0001, 1, 4'b0001, 1, 9'h0AA, 0);
        add(1, 4'b0000, 4'b0000, 0, '0, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        // single 3-word packet from requester 1
        add(1, 4'b0010, 4'b0000, 0, pk(0, 9'h101, 0, 0), 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b0010, 4'b0000, 0, pk(0, 9'h101, 0, 0), 4'b0010, 1, 4'b0010, 1, 9'h101, 0);
        add(1, 4'b0010, 4'b0000, 0, pk(0, 9'h102, 0, 0), 4'b0010, 1, 4'b0010, 1, 9'h102, 0);
        add(1, 4'b0010, 4'b0010, 0, pk(0, 9'h103, 0, 0), 4'b0010, 1, 4'b0010, 1, 9'h103, 0);
        // all requesters with 1-word packets: rotation from 2
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0100, 1, 4'b0100, 1, 9'h0A2, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b1000, 1, 4'b1000, 1, 9'h0A3, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0001, 1, 4'b0001, 1, 9'h0A0, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0010, 1, 4'b0010, 1, 9'h0A1, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0100, 1, 4'b0100, 1, 9'h0A2, 0);
        add(1, 4'b1111, 4'b1111, 0, rr, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        // owner 3 abandons immediately
        add(1, 4'b0000, 4'b0000, 0, '0, 4'b1000, 1, 4'b0000, 0, 9'h000, 0);
        // requester 0 abandons after 2 words; non-owner 2 never acked
        add(1, 4'b0001, 4'b0000, 0, pk(9'h150, 0, 0, 0), 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b0001, 4'b0000, 0, pk(9'h150, 0, 0, 0), 4'b0001, 1, 4'b0001, 1, 9'h150, 0);
        add(1, 4'b0001, 4'b0000, 0, pk(9'h151, 0, 0, 0), 4'b0001, 1, 4'b0001, 1, 9'h151, 0);
        add(1, 4'b0100, 4'b0000, 0, pk(0, 0, 9'h0AB, 0), 4'b0001, 1, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b0110, 4'b0110, 0, pk(0, 9'h1C1, 9'h1C2, 0), 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b0110, 4'b0110, 0, pk(0, 9'h1C1, 9'h1C2, 0), 4'b0010, 1, 4'b0010, 1, 9'h1C1, 0);
        // full while idle still arbitrates, then stalls the burst
        add(1, 4'b0100, 4'b0100, 1, pk(0, 0, 9'h1D2, 0), 4'b0000, 0, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b0100, 4'b0100, 1, pk(0, 0, 9'h1D2, 0), 4'b0100, 1, 4'b0000, 0, 9'h000, 0);
        add(1, 4'b0100, 4'b0100, 0, pk(0, 0, 9'h1D2, 0), 4'b0100, 1, 4'b0100, 1, 9'h1D2, 0);
        add(1, 4'b0000, 4'b0000, 0, '0, 4'b0000, 0, 4'b0000, 0, 9'h000, 0);

        for (int i = 0; i < ntv; i++) begin
            drive(tv[i].rst_n, tv[i].rq, tv[i].lst, tv[i].fl, tv[i].d);
            chk($sformatf("vec%0d", i),
                {12'd0, grant, busy, ack, write_en, wdata, trunc},
                {12'd0, tv[i].e_grant, tv[i].e_busy, tv[i].e_ack, tv[i].e_we,
                 tv[i].e_wdata, tv[i].e_trunc});
            if (tv[i].e_busy) begin
                eo = 0;
                for (int b = 0; b < 4; b++) if (tv[i].e_grant[b]) eo = b;
                chk($sformatf("vec%0d_owner", i), {30'd0, owner}, eo);
            end
        end

        // 4-word burst from requester 3 with a 3-cycle full after word 2
        exp_wc[0] = 1; exp_wc[1] = 2; exp_wc[2] = 6; exp_wc[3] = 7;
        run_stream(3, 4, 9'h031, 2, 3, 9, -1, "stall");

        // 10 words from requester 2: cut after 8, re-granted after one idle cycle
        for (int i = 0; i < 8; i++) exp_wc[i] = i + 1;
        exp_wc[8] = 10; exp_wc[9] = 11;
        run_stream(2, 10, 9'h000, -1, 0, 13, 9, "cap");

        // reset mid-burst from requester 1
        drive(1, 4'b0010, 4'b0000, 0, pk(0, 9'h0E0, 0, 0));
        chk("rst_idle_grant", {28'd0, grant}, 32'h0);
        drive(1, 4'b0010, 4'b0000, 0, pk(0, 9'h0E0, 0, 0));
        chk("rst_w1", {19'd0, grant, owner, write_en, wdata}, {19'd0, 4'b0010, 2'd1, 1'b1, 9'h0E0});
        drive(1, 4'b0010, 4'b0000, 0, pk(0, 9'h0E1, 0, 0));
        chk("rst_w2", {22'd0, write_en, wdata}, {22'd0, 1'b1, 9'h0E1});
        drive(0, 4'b0010, 4'b0000, 0, pk(0, 9'h0E2, 0, 0));
        chk("rst_sync_grant", {28'd0, grant}, 32'h2);
        drive(0, 4'b0010, 4'b0000, 0, pk(0, 9'h0E2, 0, 0));
        chk("rst_after_edge", {25'd0, grant, busy, write_en, trunc}, 32'h0);
        drive(1, 4'b1001, 4'b1001, 0, pk(9'h0F0, 0, 0, 9'h0F3));
        chk("rst_rel_idle", {28'd0, grant}, 32'h0);
        drive(1, 4'b1001, 4'b1001, 0, pk(9'h0F0, 0, 0, 9'h0F3));
        chk("rst_rrptr0", {17'd0, grant, owner, write_en, wdata}, {17'd0, 4'b0001, 2'd0, 1'b1, 9'h0F0});
        drive(1, 4'b0000, 4'b0000, 0, '0);
        chk("rst_done_grant", {28'd0, grant}, 32'h0);

        // last coincides with the 8th beat: normal release, no trunc
        for (int i = 0; i < 8; i++) exp_wc[i] = i + 1;
        run_stream(1, 8, 9'h1E0, -1, 0, 11, -1, "coin");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
